// File: rtl/pattern_rasterizer.sv
// Test-pattern pixel source for the framebuffer write path.
// Streams one frame per run with four patterns and a periodic palette swap.
module pattern_rasterizer #(
    parameter int H_RES             = 640,
    parameter int V_RES             = 480,
    parameter int X_W               = 10,
    parameter int Y_W               = 9,
    parameter int COLOR_W           = 3,
    parameter int FRAMES_PER_SWITCH = 60,
    parameter int BAR_W             = 80,
    parameter int CHECK_LOG2        = 5,
    parameter int BLANK_CYCLES      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [1:0]         pattern_sel,
    input  logic [COLOR_W-1:0] color_a,
    input  logic [COLOR_W-1:0] color_b,
    input  logic               read_rast_pixel_rdy,
    output logic               rast_pixel_rdy,
    output logic [COLOR_W-1:0] rast_color_input,
    output logic [X_W-1:0]     rast_width,
    output logic [Y_W-1:0]     rast_height,
    output logic               rast_done,
    output logic               next_frame_switch
);

    localparam int FC_W = $clog2(FRAMES_PER_SWITCH) + 1;
    localparam int BC_W = $clog2(BLANK_CYCLES) + 1;
    localparam int B_W  = (X_W > COLOR_W) ? X_W : COLOR_W;

    localparam logic [X_W-1:0]  X_LAST   = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(V_RES - 1);
    localparam logic [X_W-1:0]  BAR_LAST = X_W'(BAR_W - 1);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAMES_PER_SWITCH - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BLANK
    } state_t;

    state_t            state;
    logic [1:0]        pat;
    logic              swap;
    logic [FC_W-1:0]   frame_cnt;
    logic [BC_W-1:0]   blank_cnt;
    logic [X_W-1:0]    bar_cnt;
    logic [B_W-1:0]    bar_idx;
    logic [COLOR_W-1:0] p;
    logic [COLOR_W-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            pat               <= 2'd0;
            swap              <= 1'b0;
            frame_cnt         <= '0;
            blank_cnt         <= '0;
            bar_cnt           <= '0;
            bar_idx           <= '0;
            rast_width        <= '0;
            rast_height       <= '0;
            rast_pixel_rdy    <= 1'b0;
            rast_done         <= 1'b0;
            next_frame_switch <= 1'b0;
        end else begin
            rast_done         <= 1'b0;
            next_frame_switch <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state          <= ACTIVE;
                        rast_pixel_rdy <= 1'b1;
                        pat            <= pattern_sel;
                        rast_width     <= '0;
                        rast_height    <= '0;
                        bar_cnt        <= '0;
                        bar_idx        <= '0;
                    end
                end
                ACTIVE: begin
                    if (read_rast_pixel_rdy) begin
                        if (rast_width == X_LAST) begin
                            rast_width <= '0;
                            bar_cnt    <= '0;
                            bar_idx    <= '0;
                            if (rast_height == Y_LAST) begin
                                rast_height    <= '0;
                                state          <= BLANK;
                                rast_pixel_rdy <= 1'b0;
                                blank_cnt      <= '0;
                                rast_done      <= 1'b1;
                                if (frame_cnt == FC_LAST) begin
                                    frame_cnt         <= '0;
                                    swap              <= ~swap;
                                    next_frame_switch <= 1'b1;
                                end else begin
                                    frame_cnt <= frame_cnt + 1'b1;
                                end
                            end else begin
                                rast_height <= rast_height + 1'b1;
                            end
                        end else begin
                            rast_width <= rast_width + 1'b1;
                            if (bar_cnt == BAR_LAST) begin
                                bar_cnt <= '0;
                                bar_idx <= bar_idx + 1'b1;
                            end else begin
                                bar_cnt <= bar_cnt + 1'b1;
                            end
                        end
                    end
                end
                BLANK: begin
                    if (blank_cnt == BC_LAST) begin
                        // run is only consulted here and in IDLE
                        if (run) begin
                            state          <= ACTIVE;
                            rast_pixel_rdy <= 1'b1;
                            pat            <= pattern_sel;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        p = swap ? color_b : color_a;
        q = swap ? color_a : color_b;
        rast_color_input = p;
        unique case (pat)
            2'd0: rast_color_input = p;
            2'd1: rast_color_input =
                (rast_width[CHECK_LOG2] ^ rast_height[CHECK_LOG2]) ? q : p;
            2'd2: rast_color_input =
                bar_idx[COLOR_W-1:0] ^ {COLOR_W{swap}};
            2'd3: rast_color_input = rast_height[CHECK_LOG2] ? q : p;
            default: rast_color_input = p;
        endcase
    end

endmodule

// File: tb/tb_pattern_rasterizer.sv
// Directed bench for pattern_rasterizer on an 8x4 frame.
// Frames are counted from reset so swap state is known per frame.
module tb_pattern_rasterizer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [2:0] ca = 3'd1;
    logic [2:0] cb = 3'd5;
    logic       read_rdy = 1'b1;
    logic       rdy;
    logic [2:0] col;
    logic [2:0] wd;
    logic [1:0] ht;
    logic       done;
    logic       nfs;

    int passes = 0;
    int checks = 0;

    logic [2:0] cc [32];
    int         n_got;
    int         bad_pix;
    int         hold_bad;
    int         early;
    logic [1:0] post_done;
    logic [1:0] post_sw;
    logic [1:0] post_rdy;

    pattern_rasterizer #(
        .H_RES(8), .V_RES(4), .X_W(3), .Y_W(2), .COLOR_W(3),
        .FRAMES_PER_SWITCH(2), .BAR_W(2), .CHECK_LOG2(1),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .pattern_sel(sel),
        .color_a(ca),
        .color_b(cb),
        .read_rast_pixel_rdy(read_rdy),
        .rast_pixel_rdy(rdy),
        .rast_color_input(col),
        .rast_width(wd),
        .rast_height(ht),
        .rast_done(done),
        .next_frame_switch(nfs)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_color(input int mode, input bit sw,
                                             input int x, input int y);
        logic [2:0] pp;
        logic [2:0] qq;
        pp = sw ? cb : ca;
        qq = sw ? ca : cb;
        case (mode)
            0: return pp;
            1: return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? qq : pp;
            2: return 3'((x / 2) % 8) ^ (sw ? 3'd7 : 3'd0);
            default: return (((y >> 1) & 1) != 0) ? qq : pp;
        endcase
    endfunction

    // Records one frame of transfers plus the two blanking cycles after it.
    task automatic capture(input int mode, input bit sw, input bit stall,
                           input int chg_at, input logic [1:0] chg_sel,
                           input int run_off_at);
        logic       prev_stall;
        logic [2:0] px;
        logic [1:0] py;
        logic [2:0] pc;
        n_got = 0;
        bad_pix = 0;
        hold_bad = 0;
        early = 0;
        prev_stall = 1'b0;
        px = '0;
        py = '0;
        pc = '0;
        for (int cyc = 0; cyc < 3000 && n_got < 32; cyc++) begin
            @(negedge clk);
            read_rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (done) early++;
            if (prev_stall && (!rdy || wd != px || ht != py || col != pc))
                hold_bad++;
            prev_stall = rdy && !read_rdy;
            px = wd;
            py = ht;
            pc = col;
            if (rdy && read_rdy) begin
                cc[n_got] = col;
                if (wd !== 3'(n_got % 8) || ht !== 2'(n_got / 8) ||
                    col !== exp_color(mode, sw, n_got % 8, n_got / 8))
                    bad_pix++;
                n_got++;
                if (n_got == chg_at) sel = chg_sel;
                if (n_got == run_off_at) run = 1'b0;
            end
        end
        read_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            post_done[k] = done;
            post_sw[k]   = nfs;
            post_rdy[k]  = rdy;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b0) $display("FAIL reset_rdy got %0b exp 0", rdy);
        else passes++;
        @(negedge clk);
        checks++;
        if (wd !== 3'd0) $display("FAIL reset_x got %0d exp 0", wd);
        else passes++;
        checks++;
        if (ht !== 2'd0) $display("FAIL reset_y got %0d exp 0", ht);
        else passes++;
        checks++;
        if (done !== 1'b0 || nfs !== 1'b0)
            $display("FAIL reset_pulses got %0b%0b exp 00", done, nfs);
        else passes++;
        checks++;
        if (col !== 3'd1) $display("FAIL reset_color got %0d exp 1", col);
        else passes++;
    endtask

    task automatic test_solid();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b1;
        sel = 2'd0;
        capture(0, 1'b0, 1'b0, -1, 2'd0, -1);
        checks++;
        if (n_got !== 32) $display("FAIL f1_count got %0d exp 32", n_got);
        else passes++;
        checks++;
        if (bad_pix !== 0) $display("FAIL f1_pixels got %0d bad exp 0", bad_pix);
        else passes++;
        checks++;
        if (post_done !== 2'b01)
            $display("FAIL f1_done got %b exp 01", post_done);
        else passes++;
        checks++;
        if (post_rdy !== 2'b00) $display("FAIL f1_blank_rdy got %b exp 00", post_rdy);
        else passes++;
        checks++;
        if (post_sw !== 2'b00) $display("FAIL f1_switch got %b exp 00", post_sw);
        else passes++;
        capture(0, 1'b0, 1'b0, -1, 2'd0, -1);
        checks++;
        if (bad_pix !== 0 || n_got !== 32)
            $display("FAIL f2_pixels got %0d bad %0d seen exp 0 32", bad_pix, n_got);
        else passes++;
        checks++;
        if (post_sw !== 2'b01 || post_done !== 2'b01)
            $display("FAIL f2_switch got sw %b done %b exp 01 01", post_sw, post_done);
        else passes++;
        capture(0, 1'b1, 1'b0, -1, 2'd0, -1);
        checks++;
        if (cc[0] !== 3'd5) $display("FAIL f3_color got %0d exp 5", cc[0]);
        else passes++;
        checks++;
        if (bad_pix !== 0 || n_got !== 32)
            $display("FAIL f3_pixels got %0d bad %0d seen exp 0 32", bad_pix, n_got);
        else passes++;
        sel = 2'd2;
    endtask

    task automatic test_stall();
        capture(2, 1'b1, 1'b1, -1, 2'd0, -1);
        checks++;
        if (n_got !== 32) $display("FAIL stall_count got %0d exp 32", n_got);
        else passes++;
        checks++;
        if (bad_pix !== 0) $display("FAIL stall_pixels got %0d bad exp 0", bad_pix);
        else passes++;
        checks++;
        if (hold_bad !== 0) $display("FAIL stall_hold got %0d exp 0", hold_bad);
        else passes++;
        checks++;
        if (early !== 0) $display("FAIL stall_early_done got %0d exp 0", early);
        else passes++;
        checks++;
        if (cc[0] !== 3'd7) $display("FAIL bars_swapped_x0 got %0d exp 7", cc[0]);
        else passes++;
        checks++;
        if (post_done !== 2'b01 || post_sw !== 2'b01)
            $display("FAIL stall_end got done %b sw %b exp 01 01", post_done, post_sw);
        else passes++;
        sel = 2'd1;
    endtask

    task automatic test_checker_stripes();
        capture(1, 1'b0, 1'b0, -1, 2'd0, -1);
        checks++;
        if (cc[0] !== 3'd1 || cc[2] !== 3'd5 || cc[16] !== 3'd5 || cc[18] !== 3'd1)
            $display("FAIL checker got %0d %0d %0d %0d exp 1 5 5 1",
                     cc[0], cc[2], cc[16], cc[18]);
        else passes++;
        checks++;
        if (bad_pix !== 0) $display("FAIL checker_pixels got %0d bad exp 0", bad_pix);
        else passes++;
        sel = 2'd3;
        capture(3, 1'b0, 1'b0, -1, 2'd0, -1);
        checks++;
        if (cc[8] !== 3'd1 || cc[16] !== 3'd5)
            $display("FAIL stripes got %0d %0d exp 1 5", cc[8], cc[16]);
        else passes++;
        checks++;
        if (bad_pix !== 0) $display("FAIL stripes_pixels got %0d bad exp 0", bad_pix);
        else passes++;
        checks++;
        if (post_sw !== 2'b01) $display("FAIL f6_switch got %b exp 01", post_sw);
        else passes++;
        sel = 2'd0;
    endtask

    task automatic test_sel_midframe();
        capture(0, 1'b1, 1'b0, 10, 2'd1, -1);
        checks++;
        if (bad_pix !== 0 || n_got !== 32)
            $display("FAIL sel_cur_frame got %0d bad %0d seen exp 0 32", bad_pix, n_got);
        else passes++;
        capture(1, 1'b1, 1'b0, -1, 2'd0, -1);
        checks++;
        if (bad_pix !== 0 || n_got !== 32)
            $display("FAIL sel_next_frame got %0d bad %0d seen exp 0 32", bad_pix, n_got);
        else passes++;
    endtask

    task automatic test_run_stop();
        int rdy_hi;
        capture(1, 1'b0, 1'b0, -1, 2'd0, 5);
        checks++;
        if (bad_pix !== 0 || n_got !== 32)
            $display("FAIL run_stop_frame got %0d bad %0d seen exp 0 32", bad_pix, n_got);
        else passes++;
        checks++;
        if (post_done !== 2'b01) $display("FAIL run_stop_done got %b exp 01", post_done);
        else passes++;
        rdy_hi = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rdy !== 1'b0) rdy_hi++;
        end
        checks++;
        if (rdy_hi !== 0) $display("FAIL run_stop_idle got %0d rdy cycles exp 0", rdy_hi);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        run = 1'b1;
        sel = 2'd3;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (rdy && wd == 3'd3 && ht == 2'd2) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL mid_reach got 0 exp 1");
        else passes++;
        checks++;
        if (col !== 3'd5) $display("FAIL mid_color_pre got %0d exp 5", col);
        else passes++;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b0 || wd !== 3'd0 || ht !== 2'd0)
            $display("FAIL mid_reset_coord got rdy %0b x %0d y %0d exp 0 0 0", rdy, wd, ht);
        else passes++;
        checks++;
        if (col !== 3'd1 || done !== 1'b0 || nfs !== 1'b0)
            $display("FAIL mid_reset_out got col %0d done %0b sw %0b exp 1 0 0",
                     col, done, nfs);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        sel = 2'd2;
    endtask

    task automatic test_bars();
        capture(2, 1'b0, 1'b0, -1, 2'd0, -1);
        checks++;
        if (cc[0] !== 3'd0 || cc[1] !== 3'd0 || cc[2] !== 3'd1 || cc[3] !== 3'd1)
            $display("FAIL bars_left got %0d %0d %0d %0d exp 0 0 1 1",
                     cc[0], cc[1], cc[2], cc[3]);
        else passes++;
        checks++;
        if (cc[6] !== 3'd3 || cc[7] !== 3'd3 || cc[8] !== 3'd0)
            $display("FAIL bars_right got %0d %0d %0d exp 3 3 0", cc[6], cc[7], cc[8]);
        else passes++;
        checks++;
        if (bad_pix !== 0 || n_got !== 32)
            $display("FAIL bars_pixels got %0d bad %0d seen exp 0 32", bad_pix, n_got);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_solid();
        test_stall();
        test_checker_stripes();
        test_sel_midframe();
        test_run_stop();
        test_reset_mid();
        test_bars();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
